// File: rtl/spi_pkg.sv
//------------------------------------------------------------------------------
// spi_pkg : shared mode/state encodings and CPOL/CPHA helpers for the SPI master
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package spi_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LEAD  = 3'd2,
    TRAIL = 3'd3,
    HOLD  = 3'd4
  } spi_master_state_e;

  function automatic logic get_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic get_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_master_if.sv
//------------------------------------------------------------------------------
// spi_master_if : processor-side controls plus SPI pins of the SPI master
// Revision: 1.0  (LoopBack present only with SPI_MASTER_LOOPBACK_EN)
//------------------------------------------------------------------------------
`default_nettype none

interface spi_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV_W  = 8
);
  logic [1:0]            MODE;
  logic [CLK_DIV_W-1:0]  ClkDiv;
  logic                  Start;
  logic [DATA_WIDTH-1:0] TxData;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] RxData;
  logic                  SClk;
  logic                  MOSI;
  logic                  SS;
  logic                  MISO;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic                  LoopBack;
`endif

  modport master (
    input  MODE, ClkDiv, Start, TxData, MISO,
    output Busy, Done, RxData, SClk, MOSI, SS
`ifdef SPI_MASTER_LOOPBACK_EN
    , input LoopBack
`endif
  );

  modport slave (
    input  SClk, MOSI, SS,
    output MISO
  );

endinterface

`default_nettype wire

// File: rtl/spi_clk_div.sv
//------------------------------------------------------------------------------
// spi_clk_div : loadable down-counter, Tick once every ClkDiv+1 enabled cycles
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_clk_div #(
  parameter int CLK_DIV_W = 8
) (
  input  wire                 Clk,
  input  wire                 Rst,
  input  wire                 En,
  input  wire                 Load,
  input  wire [CLK_DIV_W-1:0] ClkDiv,
  output logic                Tick
);

  logic [CLK_DIV_W-1:0] r_cnt;

  assign Tick = En && (r_cnt == '0);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_cnt <= '0;
    end else if (Load) begin
      r_cnt <= ClkDiv;
    end else if (En) begin
      r_cnt <= (r_cnt == '0) ? ClkDiv : r_cnt - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
//------------------------------------------------------------------------------
// spi_master : full-duplex MSB-first SPI master, all four CPOL/CPHA modes
// Revision: 1.0  (option macro: SPI_MASTER_LOOPBACK_EN)
//------------------------------------------------------------------------------
`default_nettype none

module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV_W  = 8
) (
  input wire           Clk,
  input wire           Rst,
  spi_master_if.master bus
);

  localparam int                CNT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  C_FULL = CNT_W'(DATA_WIDTH);

  spi_master_state_e     r_state;
  spi_mode_e             r_mode;
  logic [CLK_DIV_W-1:0]  r_div;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [DATA_WIDTH-1:0] r_rx;
  logic [DATA_WIDTH-1:0] r_rxdata;
  logic [CNT_W-1:0]      r_bits;
  logic                  r_sclk, r_mosi, r_ss, r_busy, r_done;

  logic                  w_tick, w_start, w_cpha, w_miso_in;
  logic [CLK_DIV_W-1:0]  w_div;

  // The Done cycle itself never accepts Start, guaranteeing an SS-high gap.
  assign w_start = (r_state == IDLE) && bus.Start && !r_done;
  assign w_cpha  = get_cpha(r_mode);
  assign w_div   = (r_state == IDLE) ? bus.ClkDiv : r_div;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic r_lb;
  always_ff @(posedge Clk) begin
    if (Rst)          r_lb <= 1'b0;
    else if (w_start) r_lb <= bus.LoopBack;
  end
  assign w_miso_in = r_lb ? r_mosi : bus.MISO;
`else
  assign w_miso_in = bus.MISO;
`endif

  spi_clk_div #(.CLK_DIV_W(CLK_DIV_W)) u_div (
    .Clk    (Clk),
    .Rst    (Rst),
    .En     (r_state != IDLE),
    .Load   (w_start),
    .ClkDiv (w_div),
    .Tick   (w_tick)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
      r_mode  <= MODE0;
      r_div   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_bits  <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_ss    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      // An aborted frame leaves the previously delivered word visible.
      if (!r_busy) r_rxdata <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sclk <= get_cpol(bus.MODE);
          if (w_start) begin
            r_mode  <= spi_mode_e'(bus.MODE);
            r_div   <= bus.ClkDiv;
            r_ss    <= 1'b0;
            r_busy  <= 1'b1;
            r_bits  <= '0;
            r_rx    <= '0;
            r_state <= SETUP;
            if (!get_cpha(bus.MODE)) begin
              r_mosi <= bus.TxData[DATA_WIDTH-1];
              r_tx   <= bus.TxData << 1;
            end else begin
              r_tx   <= bus.TxData;
            end
          end
        end
        SETUP, TRAIL: begin
          if (w_tick) begin
            if (r_state == TRAIL && r_bits == C_FULL) begin
              r_state <= HOLD;
            end else begin
              r_state <= LEAD;
              r_sclk  <= ~get_cpol(r_mode);
              if (w_cpha) begin
                r_mosi <= r_tx[DATA_WIDTH-1];
                r_tx   <= r_tx << 1;
              end else begin
                r_rx   <= {r_rx[DATA_WIDTH-2:0], w_miso_in};
              end
            end
          end
        end
        LEAD: begin
          if (w_tick) begin
            r_state <= TRAIL;
            r_sclk  <= get_cpol(r_mode);
            r_bits  <= r_bits + 1'b1;
            if (w_cpha) begin
              r_rx <= {r_rx[DATA_WIDTH-2:0], w_miso_in};
            end else if (r_bits != C_LAST) begin
              r_mosi <= r_tx[DATA_WIDTH-1];
              r_tx   <= r_tx << 1;
            end
          end
        end
        HOLD: begin
          if (w_tick) begin
            r_state  <= IDLE;
            r_ss     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_rxdata <= r_rx;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Busy   = r_busy;
  assign bus.Done   = r_done;
  assign bus.RxData = r_rxdata;
  assign bus.SClk   = r_sclk;
  assign bus.MOSI   = r_mosi;
  assign bus.SS     = r_ss;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
//------------------------------------------------------------------------------
// tb_spi_master : vector table of SPI exchanges against a behavioural slave
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_master;

  logic Clk = 1'b0;
  logic Rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  spi_master_if #(.DATA_WIDTH(32), .CLK_DIV_W(8)) bus ();

  spi_master #(.DATA_WIDTH(32), .CLK_DIV_W(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.master)
  );

  // Behavioural slave: loads on SS fall, shifts MSB first per CPOL/CPHA.
  logic [31:0] s_tx = '0, s_sh = '0, s_rx = '0;
  logic [1:0]  s_mode = 2'b00;
  logic        s_miso = 1'b0, miso_zero = 1'b0;
  logic        p_ss = 1'b1, p_sclk = 1'b0;
  int          s_rise = 0, s_fall = 0;

  assign bus.MISO = miso_zero ? 1'b0 : s_miso;

  always @(bus.SS or bus.SClk) begin
    if (p_ss === 1'b1 && bus.SS === 1'b0) begin
      s_sh = s_tx; s_rx = '0; s_rise = 0; s_fall = 0;
      if (!s_mode[0]) s_miso = s_sh[31];
    end else if (bus.SS === 1'b0 && bus.SClk !== p_sclk) begin
      if (bus.SClk) s_rise++; else s_fall++;
      if (bus.SClk != s_mode[1]) begin
        if (!s_mode[0]) s_rx = {s_rx[30:0], bus.MOSI};
        else begin s_miso = s_sh[31]; s_sh = s_sh << 1; end
      end else begin
        if (s_mode[0]) s_rx = {s_rx[30:0], bus.MOSI};
        else begin s_sh = s_sh << 1; s_miso = s_sh[31]; end
      end
    end
    p_ss = bus.SS; p_sclk = bus.SClk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic setup_frame(input logic [1:0] m, input logic [7:0] d,
                             input logic [31:0] mtx, input logic [31:0] stx);
    @(negedge Clk);
    bus.MODE = m; bus.ClkDiv = d; bus.TxData = mtx; s_tx = stx; s_mode = m;
    repeat (3) @(negedge Clk);
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [7:0] d, input logic [31:0] mtx,
                           input logic [31:0] stx, input bit chg, input int lat_exp, input string tag);
    int t0;
    setup_frame(m, d, mtx, stx);
    check1({tag, "_sclk_idle_pre"}, bus.SClk, m[1]);
    bus.Start = 1'b1; t0 = cyc;
    @(negedge Clk);
    bus.Start = 1'b0;
    check1({tag, "_busy"}, bus.Busy, 1'b1);
    while (!bus.Done && (cyc - t0) < 5000) begin
      if (chg && (cyc - t0) == 20) begin bus.MODE = 2'b11; bus.TxData = '0; end
      @(negedge Clk);
    end
    check1({tag, "_done_seen"}, bus.Done, 1'b1);
    check({tag, "_latency"}, cyc - t0, lat_exp);
    check1({tag, "_ss_at_done"}, bus.SS, 1'b1);
    check({tag, "_master_rx"}, bus.RxData, stx);
    check({tag, "_slave_rx"}, s_rx, mtx);
    check({tag, "_rise_edges"}, s_rise, 32);
    check({tag, "_fall_edges"}, s_fall, 32);
    @(negedge Clk);
    check1({tag, "_done_width"}, bus.Done, 1'b0);
    check1({tag, "_busy_clear"}, bus.Busy, 1'b0);
    @(negedge Clk);
    check1({tag, "_sclk_idle_post"}, bus.SClk, bus.MODE[1]);
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  div;
    logic [31:0] mtx;
    logic [31:0] stx;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int t0, nd, dt[4];
    logic prev_done;

    vecs[0] = '{2'd0, 8'd2, 32'hA5C3_0F81, 32'h1234_5678, 199};
    vecs[1] = '{2'd1, 8'd2, 32'hA5C3_0F81, 32'h1234_5678, 199};
    vecs[2] = '{2'd2, 8'd2, 32'hA5C3_0F81, 32'h1234_5678, 199};
    vecs[3] = '{2'd3, 8'd2, 32'hA5C3_0F81, 32'h1234_5678, 199};
    vecs[4] = '{2'd0, 8'd0, 32'h8000_0001, 32'hFFFF_0000,  67};
    vecs[5] = '{2'd3, 8'd1, 32'h0000_0000, 32'hFFFF_FFFF, 133};
    vecs[6] = '{2'd1, 8'd4, 32'h5A5A_5A5A, 32'h0F0F_0F0F, 331};

    Rst = 1'b1;
    bus.Start = 1'b0; bus.MODE = 2'b00; bus.ClkDiv = 8'd2; bus.TxData = '0;
`ifdef SPI_MASTER_LOOPBACK_EN
    bus.LoopBack = 1'b0;
`endif
    repeat (4) @(negedge Clk);
    check1("rst_ss", bus.SS, 1'b1);
    check1("rst_sclk", bus.SClk, 1'b0);
    check1("rst_mosi", bus.MOSI, 1'b0);
    check1("rst_busy", bus.Busy, 1'b0);
    check1("rst_done", bus.Done, 1'b0);
    check("rst_rxdata", bus.RxData, 32'h0);
    Rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].mode, vecs[i].div, vecs[i].mtx, vecs[i].stx, 1'b0, vecs[i].lat,
                $sformatf("vec%0d", i));

    // MODE/TxData changed mid-frame must not disturb the frame in flight.
    run_frame(2'd0, 8'd2, 32'hC0FF_EE11, 32'h1357_9BDF, 1'b1, 199, "midchg");

    // Start held high: back-to-back frames spaced by the Done cycle plus one.
    setup_frame(2'd0, 8'd2, 32'h3C3C_A5A5, 32'h6B6B_0102);
    bus.Start = 1'b1; t0 = cyc; nd = 0; prev_done = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge Clk);
      if (i == 499) bus.Start = 1'b0;
      if (prev_done) check1("b2b_ss_gap", bus.SS, 1'b1);
      if (bus.Done) begin
        check1("b2b_ss_on_done", bus.SS, 1'b1);
        if (nd < 4) dt[nd] = cyc;
        nd++;
      end
      prev_done = bus.Done;
    end
    check("b2b_done_count", nd, 3);
    check("b2b_first_latency", dt[0] - t0, 199);
    check("b2b_spacing_1", dt[1] - dt[0], 200);
    check("b2b_spacing_2", dt[2] - dt[1], 200);
    check("b2b_master_rx", bus.RxData, 32'h6B6B_0102);
    check("b2b_slave_rx", s_rx, 32'h3C3C_A5A5);

    // Reset 50 cycles into a frame aborts it and keeps the earlier RxData.
    setup_frame(2'd0, 8'd2, 32'hFACE_0000, 32'h0000_CAFE);
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (49) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check1("abort_ss", bus.SS, 1'b1);
    check1("abort_busy", bus.Busy, 1'b0);
    check1("abort_done", bus.Done, 1'b0);
    check("abort_rxdata", bus.RxData, 32'h6B6B_0102);
    nd = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (bus.Done) nd++;
    end
    check("abort_no_done", nd, 0);
    run_frame(2'd2, 8'd2, 32'h0BAD_F00D, 32'h7777_1111, 1'b0, 199, "post_abort");

`ifdef SPI_MASTER_LOOPBACK_EN
    miso_zero = 1'b1;
    bus.LoopBack = 1'b1;
    setup_frame(2'd0, 8'd2, 32'hDEAD_BEEF, 32'h0000_0000);
    bus.Start = 1'b1; t0 = cyc;
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.LoopBack = 1'b0;
    while (!bus.Done && (cyc - t0) < 5000) @(negedge Clk);
    check1("lb_done_seen", bus.Done, 1'b1);
    check("lb_rxdata", bus.RxData, 32'hDEAD_BEEF);
    miso_zero = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
